// File: rtl/risc_core_param_if.sv
// Shared program/data memory port between the core (master) and a memory (slave).
// Latency: pure wiring. data is the resolved bus: the core drives it while wr=1, the memory while mem_oe=1.
// Backpressure: the memory holds mem_ready low to add wait states; the core keeps addr/strobes/wdata stable.
interface risc_core_param_if #(
  parameter int DW = 8,
  parameter int AW = 13
);
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [DW-1:0] wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_dout;
  logic          mem_oe;
  wire  [DW-1:0] data;

  // Single resolution point for the bidirectional data bus; high-Z when nobody drives.
  assign data = wr ? wdata : (mem_oe ? mem_dout : {DW{1'bz}});

  modport master (output addr, rd, wr, wdata, input mem_ready, data);
  modport slave  (input addr, rd, wr, wdata, output mem_ready, mem_dout, mem_oe, input data);
endinterface

// File: rtl/risc_core_param.sv
// Multi-cycle accumulator core: PC, IR, accumulator, ALU and one controller FSM on a shared memory port.
// Latency: ALU/LDA/STO 4 cycles, JMP/SKZ/HLT 3 cycles at zero wait; each low mem_ready cycle adds one.
// Backpressure: mem_ready honoured only when RISC_CORE_WAIT_EN is defined; otherwise every access takes one edge.
module risc_core_param #(
  parameter int DW = 8,   // data/accumulator width, at least 4
  parameter int AW = 13   // address/PC width, 3+AW must fit in 2*DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  output logic               halt,
  risc_core_param_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH_HI = 3'd0,
    FETCH_LO = 3'd1,
    DECODE   = 3'd2,
    OPER_RD  = 3'd3,
    OPER_WR  = 3'd4,
    HALTED   = 3'd5
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [2*DW-1:0] ir_q, ir_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            halt_q, halt_d;
  logic            done;
  logic [2:0]      opcode;
  logic [AW-1:0]   opnd;

`ifdef RISC_CORE_WAIT_EN
  assign done = bus.mem_ready;
`else
  // Port kept for pin compatibility; every access completes on its first edge.
  logic unused_ready;
  assign unused_ready = bus.mem_ready;
  assign done = 1'b1;
`endif

  assign opcode = ir_q[2*DW-1 -: 3];
  assign opnd   = ir_q[AW-1:0];

  // Next-state, datapath and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH_HI: if (done) begin
        ir_d[2*DW-1:DW] = bus.data;
        pc_d            = pc_q + AW'(1);
        state_d         = FETCH_LO;
      end
      FETCH_LO: if (done) begin
        ir_d[DW-1:0] = bus.data;
        pc_d         = pc_q + AW'(1);
        state_d      = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_HLT: state_d = HALTED;
          OP_SKZ: begin
            if (acc_q == '0) pc_d = pc_q + AW'(2);
            state_d = FETCH_HI;
          end
          OP_JMP: begin
            pc_d    = opnd;
            state_d = FETCH_HI;
          end
          OP_STO:  state_d = OPER_WR;
          default: state_d = OPER_RD;
        endcase
      end
      OPER_RD: if (done) begin
        case (opcode)
          OP_ADD:  acc_d = acc_q + bus.data;
          OP_AND:  acc_d = acc_q & bus.data;
          OP_XOR:  acc_d = acc_q ^ bus.data;
          default: acc_d = bus.data;
        endcase
        state_d = FETCH_HI;
      end
      OPER_WR: if (done) state_d = FETCH_HI;
      HALTED:  if (go) state_d = FETCH_HI;
      default: state_d = FETCH_HI;
    endcase

    rd_d   = (state_d == FETCH_HI) || (state_d == FETCH_LO) || (state_d == OPER_RD);
    wr_d   = (state_d == OPER_WR);
    halt_d = (state_d == HALTED);
    addr_d = ((state_d == OPER_RD) || (state_d == OPER_WR)) ? ir_d[AW-1:0] : pc_d;
  end

  // State, architectural registers and registered bus outputs; reset aborts any access at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH_HI;
      pc_q    <= '0;
      acc_q   <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b1;
      wr_q    <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      halt_q  <= halt_d;
    end
  end

  // rd is masked while reset is held so no strobe is seen during reset; it reappears on release.
  assign bus.addr  = addr_q;
  assign bus.rd    = rd_q & ~reset;
  assign bus.wr    = wr_q;
  assign bus.wdata = acc_q;
  assign halt      = halt_q;

endmodule

// File: tb/tb_risc_core_param.sv
// Directed bench for risc_core_param (DW=8, AW=13) with a behavioural memory and wait-state generator.
module tb_risc_core_param;

`ifdef RISC_CORE_WAIT_EN
  localparam int W = 3;
`else
  localparam int W = 0;
`endif

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic go = 1'b0;
  logic halt;
  int   checks = 0;
  int   errors = 0;
  int   wait_n = 0;
  int   wcnt;

  logic [7:0]  mem [0:8191];
  logic        ld_en = 1'b0;
  logic [12:0] ld_a = '0;
  logic [7:0]  ld_d = '0;

  risc_core_param_if #(.DW(8), .AW(13)) bus ();

  risc_core_param #(.DW(8), .AW(13)) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .halt  (halt),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the completing edge, plus a load port for programs.
  assign bus.mem_oe    = bus.rd;
  assign bus.mem_dout  = mem[bus.addr];
  assign bus.mem_ready = (wcnt >= wait_n);

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (bus.wr && ((W == 0) || bus.mem_ready)) mem[bus.addr] <= bus.data;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if ((bus.rd || bus.wr) && !bus.mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic poke(input logic [12:0] a, input logic [7:0] d);
    ld_a  = a;
    ld_d  = d;
    ld_en = 1'b1;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic ins(input logic [12:0] a, input logic [2:0] op, input logic [12:0] opnd);
    poke(a, {op, opnd[12:8]});
    poke(a + 13'd1, opnd[7:0]);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic bad;

    // Test 1: basic program, reset values and cycle-exact timing.
    reset = 1'b1;
    ins(13'h000, LDA, 13'h100);
    ins(13'h002, ADD, 13'h101);
    ins(13'h004, STO, 13'h102);
    ins(13'h006, HLT, 13'h000);
    poke(13'h100, 8'h7F);
    poke(13'h101, 8'h02);
    poke(13'h102, 8'h00);
    chk("rst_wr",   32'(bus.wr),   32'h0);
    chk("rst_halt", 32'(halt),     32'h0);
    chk("rst_rd",   32'(bus.rd),   32'h0);
    chk("rst_addr", 32'(bus.addr), 32'h0);
    release_reset();
    chk("rel_rd",   32'(bus.rd),   32'h1);
    chk("rel_addr", 32'(bus.addr), 32'h0);
    step(1);
    chk("t1_fetch_lo", 32'(bus.addr), 32'h001);
    step(2);
    chk("t1_oper_addr", 32'(bus.addr), 32'h100);
    chk("t1_oper_rd",   32'(bus.rd),   32'h1);
    step(8);
    chk("t1_sto_wr",   32'(bus.wr),   32'h1);
    chk("t1_sto_addr", 32'(bus.addr), 32'h102);
    chk("t1_sto_data", 32'(bus.data), 32'h81);
    step(3);
    chk("t1_halt_14", 32'(halt), 32'h0);
    step(1);
    chk("t1_halt_15", 32'(halt),     32'h1);
    chk("t1_h_addr",  32'(bus.addr), 32'h008);
    chk("t1_h_rd",    32'(bus.rd),   32'h0);
    chk("t1_mem",     32'(mem[13'h102]), 32'h81);

    // Test 2: ADD overflow to zero, SKZ taken skips the next instruction.
    reset = 1'b1;
    ins(13'h000, LDA, 13'h200);
    ins(13'h002, ADD, 13'h201);
    ins(13'h004, SKZ, 13'h000);
    ins(13'h006, STO, 13'h202);
    ins(13'h008, STO, 13'h203);
    ins(13'h00A, HLT, 13'h000);
    poke(13'h200, 8'hFF);
    poke(13'h201, 8'h01);
    poke(13'h202, 8'h55);
    poke(13'h203, 8'hAA);
    release_reset();
    step(11);
    chk("t2_skz_addr", 32'(bus.addr), 32'h008);
    step(6);
    chk("t2_halt_17", 32'(halt), 32'h0);
    step(1);
    chk("t2_halt",    32'(halt),     32'h1);
    chk("t2_h_addr",  32'(bus.addr), 32'h00C);
    chk("t2_skipped", 32'(mem[13'h202]), 32'h55);
    chk("t2_sum0",    32'(mem[13'h203]), 32'h00);

    // Test 3: AND/XOR, SKZ not taken, optional wait states on every access.
    reset = 1'b1;
    wait_n = W;
    ins(13'h000, LDA, 13'h300);
    ins(13'h002, AND, 13'h301);
    ins(13'h004, XOR, 13'h302);
    ins(13'h006, SKZ, 13'h000);
    ins(13'h008, STO, 13'h303);
    ins(13'h00A, HLT, 13'h000);
    poke(13'h300, 8'hF0);
    poke(13'h301, 8'h3C);
    poke(13'h302, 8'h0F);
    poke(13'h303, 8'h00);
    release_reset();
    for (int i = 0; i < W; i++) begin
      step(1);
      chk("t3_hold_addr", 32'(bus.addr), 32'h000);
      chk("t3_hold_rd",   32'(bus.rd),   32'h1);
    end
    step(1);
    chk("t3_first_done", 32'(bus.addr), 32'h001);
    step(17 + 13 * W - W);
    for (int i = 0; i <= W; i++) begin
      chk("t3_wr",   32'(bus.wr),   32'h1);
      chk("t3_addr", 32'(bus.addr), 32'h303);
      chk("t3_data", 32'(bus.data), 32'h3F);
      step(1);
    end
    chk("t3_after_wr", 32'(bus.addr), 32'h00A);
    chk("t3_after_rd", 32'(bus.rd),   32'h1);
    step(2 + 2 * W);
    chk("t3_not_halt", 32'(halt), 32'h0);
    step(1);
    chk("t3_halt", 32'(halt), 32'h1);
    chk("t3_mem",  32'(mem[13'h303]), 32'h3F);
    wait_n = 0;

    // Test 4: PC wrap through 0x1FFF.
    reset = 1'b1;
    ins(13'h000,  JMP, 13'h1FFE);
    ins(13'h1FFE, JMP, 13'h0010);
    ins(13'h010,  HLT, 13'h000);
    release_reset();
    step(3);
    chk("t4_jmp_hi", 32'(bus.addr), 32'h1FFE);
    step(1);
    chk("t4_jmp_lo", 32'(bus.addr), 32'h1FFF);
    step(2);
    chk("t4_jmp_tgt", 32'(bus.addr), 32'h0010);
    step(3);
    chk("t4_halt",   32'(halt),     32'h1);
    chk("t4_h_addr", 32'(bus.addr), 32'h0012);
    reset = 1'b1;
    ins(13'h1FFE, HLT, 13'h000);
    release_reset();
    step(6);
    chk("t4_wrap_halt", 32'(halt),     32'h1);
    chk("t4_wrap_pc",   32'(bus.addr), 32'h0000);

    // Test 5: halt, go ignored outside HALTED, restart on go.
    reset = 1'b1;
    ins(13'h000, HLT, 13'h000);
    ins(13'h002, LDA, 13'h500);
    ins(13'h004, STO, 13'h501);
    ins(13'h006, HLT, 13'h000);
    poke(13'h500, 8'h5A);
    poke(13'h501, 8'h00);
    release_reset();
    step(2);
    go = 1'b1;
    step(1);
    go = 1'b0;
    chk("t5_halt",   32'(halt),     32'h1);
    chk("t5_h_addr", 32'(bus.addr), 32'h002);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.rd || bus.wr || !halt) bad = 1'b1;
    end
    chk("t5_quiet", 32'(bad), 32'h0);
    go = 1'b1;
    step(1);
    go = 1'b0;
    chk("t5_go_rd",   32'(bus.rd),   32'h1);
    chk("t5_go_addr", 32'(bus.addr), 32'h002);
    chk("t5_go_halt", 32'(halt),     32'h0);
    step(10);
    chk("t5_not_halt", 32'(halt), 32'h0);
    step(1);
    chk("t5_halt2",   32'(halt),     32'h1);
    chk("t5_h2_addr", 32'(bus.addr), 32'h008);
    chk("t5_mem",     32'(mem[13'h501]), 32'h5A);

    // Test 6: asynchronous reset during a stalled write.
    reset = 1'b1;
    wait_n = W;
    ins(13'h000, STO, 13'h600);
    poke(13'h600, 8'h77);
    release_reset();
    step(3);
    chk("t6_wr_on",   32'(bus.wr),   32'h1);
    chk("t6_wr_addr", 32'(bus.addr), 32'h600);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_wr_drop", 32'(bus.wr),   32'h0);
    chk("t6_rd_drop", 32'(bus.rd),   32'h0);
    chk("t6_addr0",   32'(bus.addr), 32'h000);
    step(2);
    chk("t6_mem", 32'(mem[13'h600]), 32'h77);
    wait_n = 0;
    release_reset();
    chk("t6_restart_rd",   32'(bus.rd),   32'h1);
    chk("t6_restart_addr", 32'(bus.addr), 32'h000);
    step(1);
    chk("t6_restart_lo", 32'(bus.addr), 32'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_core_param.md
# risc_core_param

Parametrised multi-cycle accumulator RISC core, the next generation of the 8-bit/13-bit CPU top level. It adds generic data and address widths, a memory wait-state handshake, and a restart-from-halt input. Internally it integrates the PC, IR, accumulator, ALU and a single controller FSM. It sits between the testbench/SoC clock-reset and a single shared program/data memory port.

## Interface

Parameters:
- DW, 8, data bus and accumulator width; minimum 4.
- AW, 13, address/PC width; constraint 3+AW <= 2*DW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  reset; asynchronous, active-high.
- go  input  1  single-cycle pulse; leaves HALTED.
- mem_ready  input  1  memory access completes on an edge where it is high.
- data  inout  DW  memory data; the core drives it only while wr=1, otherwise high-Z.
- addr  output  AW  memory address.
- rd  output  1  read strobe.
- wr  output  1  write strobe.
- halt  output  1  high while in HALTED.

## Operation

- Instruction word is 2*DW bits, fetched high beat first, then low beat:
  - opcode = word[2*DW-1 -: 3];
  - operand address = word[AW-1:0];
  - remaining bits are ignored.
- Opcodes:
  - 000 HLT: enter HALTED.
  - 001 SKZ: if accum==0, pc += 2.
  - 010 ADD: accum = accum + M[a], modulo 2^DW; carry discarded.
  - 011 AND: accum = accum & M[a].
  - 100 XOR: accum = accum ^ M[a].
  - 101 LDA: accum = M[a].
  - 110 STO: M[a] = accum.
  - 111 JMP: pc = a.
- FSM states:
  - FETCH_HI: rd=1, addr=pc. On completion: ir_hi <= data, pc++, go to FETCH_LO.
  - FETCH_LO: rd=1, addr=pc. On completion: ir_lo <= data, pc++, go to DECODE.
  - DECODE (no bus activity):
    - ALU ops and LDA -> OPER_RD.
    - STO -> OPER_WR.
    - JMP and SKZ update pc, then -> FETCH_HI.
    - HLT -> HALTED.
  - OPER_RD: rd=1, addr=a. On completion: accum updated, go to FETCH_HI.
  - OPER_WR: wr=1, addr=a, data=accum. On completion: go to FETCH_HI.
  - HALTED: halt=1, rd=wr=0, addr=pc. Sampling go=1 moves to FETCH_HI; go is ignored in every other state.
- PC is AW bits and wraps from 2^AW-1 to 0, including on SKZ and fetch increments.
- Zero flag = (accum==0), evaluated in DECODE.

## Timing

- rd, wr, halt and addr are decoded from registered state and registers only: glitch-free, no combinational path from mem_ready.
- Bus access: strobe and addr are valid from the state-entry edge. The access completes on the first rising edge with mem_ready=1; read data is captured on that edge.
- With zero wait states:
  - ALU/LDA/STO instructions take 4 cycles.
  - JMP/SKZ take 3 cycles.
  - HLT takes 3 cycles, then HALTED.
- Each low cycle of mem_ready adds exactly one cycle; strobe, addr and write data are held stable throughout.
- Reset values, asynchronous:
  - pc=0, accum=0, ir=0, state=FETCH_HI.
  - First edge after reset release begins the fetch at addr 0 (rd=1 visible immediately after release).
  - halt=0, wr=0, data high-Z.
- Reset mid-access: strobes drop and state returns to FETCH_HI immediately; a pending write is abandoned.
- go arriving in the same cycle HLT is decoded has no effect; go must be sampled while in HALTED.

## Configuration

- RISC_CORE_WAIT_EN:
  - Defined: mem_ready is honoured as above.
  - Undefined: mem_ready is ignored and every access completes on the first edge; the port remains present but unused.

## Test plan

- Reset with DW=8, AW=13, zero wait:
  - After release, first edge fetches addr 0,1.
  - Program LDA 0x100 (M=0x7F), ADD 0x101 (M=0x02), STO 0x102, HLT -> M[0x102]=0x81, halt=1 at cycle 15.
- Overflow: LDA 0xFF, ADD 0x01 -> accum=0x00; following SKZ skips the next instruction (pc += 2).
- Wait states with RISC_CORE_WAIT_EN: mem_ready low for 3 cycles on every access -> each access stretched by 3 cycles, addr/rd/wr/data stable, final memory results identical.
- PC wrap with AW=13: JMP 0x1FFE, instruction there is JMP 0x0010 -> fetches at 0x1FFE, 0x1FFF, then next fetch at 0x0010; pc passing 0x1FFF wraps to 0x0000.
- Halt/restart: HLT at 0x000 -> halt=1, addr=0x002, no strobes for 20 cycles; go pulse -> fetch resumes at 0x002.
- Async reset asserted during OPER_WR with mem_ready low -> wr falls without a clock edge, memory unchanged, restart at addr 0.
